// File: rtl/cnn_fc_core_ctl_gen.sv
// CNN/FC core controller: muxes operand bundles onto a shared external MAC,
// tracks in-flight beats with a tag pipeline, accumulates FC partial sums,
// quantises results, and buffers FC outputs in a ready/valid FIFO.
module cnn_fc_core_ctl_gen #(
  parameter int unsigned VEC_W     = 72,
  parameter int unsigned SUM_W     = 20,
  parameter int unsigned FC_PARTS  = 3,
  parameter int unsigned MAC_LAT   = 2,
  parameter int unsigned QSHIFT    = 4,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cnn_valid,
  input  logic [VEC_W-1:0]            cnn_data,
  input  logic [VEC_W-1:0]            filter_data,
  output logic                        cnn_ack,
  input  logic                        fc_valid,
  input  logic [VEC_W-1:0]            fc_data,
  input  logic [VEC_W-1:0]            weight_data,
  input  logic                        fc_clear,
  output logic [VEC_W-1:0]            mac_kernel,
  output logic [VEC_W-1:0]            mac_weight,
  input  logic [SUM_W-1:0]            mac_sum,
  output logic                        cnn_out,
  output logic [OUT_W-1:0]            cnn_data_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [$clog2(FC_PARTS)-1:0] fc_part_idx,
  output logic                        sat_flag,
  output logic                        ovf
);

  localparam int unsigned IDX_W  = $clog2(FC_PARTS);
  localparam int unsigned ACC_W  = SUM_W + IDX_W;
  localparam int unsigned Q_W    = ACC_W + 1;
  localparam int unsigned PTR_W  = $clog2(OUT_DEPTH);
  localparam int unsigned RND_SH = (QSHIFT > 0) ? QSHIFT - 1 : 0;
  localparam logic signed [Q_W-1:0] RND   = (QSHIFT > 0) ? (Q_W'(1) << RND_SH) : '0;
  localparam logic signed [Q_W-1:0] Q_MAX = Q_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [Q_W-1:0] Q_MIN = ~Q_MAX;

  // Tag pipeline state
  logic [MAC_LAT-1:0] tag_fc;
  logic [MAC_LAT-1:0] tag_cnn;
  logic               ex_fc;
  logic               ex_cnn;

  // Accumulator and quantiser
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] fc_total;
  logic signed [ACC_W-1:0] q_in;
  logic signed [Q_W-1:0]   q_rnd;
  logic signed [Q_W-1:0]   q_sh;
  logic [OUT_W-1:0]        q_res;
  logic                    q_sat_c;
  logic                    last_part;
  logic                    q_fc_v;
  logic [OUT_W-1:0]        q_data;

  // Output FIFO
  logic [OUT_W-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             do_push;

  assign cnn_ack    = cnn_valid & ~fc_valid;
  assign mac_kernel = fc_valid ? fc_data : cnn_data;
  assign mac_weight = fc_valid ? weight_data : filter_data;

  // An exiting FC tag is killed by fc_clear in the same cycle.
  assign ex_fc     = tag_fc[MAC_LAT-1] & ~fc_clear;
  assign ex_cnn    = tag_cnn[MAC_LAT-1];
  assign last_part = (fc_part_idx == IDX_W'(FC_PARTS - 1));

  // Shift issue tags along with the MAC latency; fc_clear wipes all FC tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_fc  <= '0;
      tag_cnn <= '0;
    end else begin
      tag_cnn[0] <= cnn_ack;
      tag_fc[0]  <= fc_valid & ~fc_clear;
      for (int unsigned i = 1; i < MAC_LAT; i++) begin
        tag_cnn[i] <= tag_cnn[i-1];
        tag_fc[i]  <= tag_fc[i-1] & ~fc_clear;
      end
    end
  end

  // Select quantiser input, round, shift and clamp
  always_comb begin
    sum_ext  = {{IDX_W{mac_sum[SUM_W-1]}}, mac_sum};
    fc_total = acc + sum_ext;
    q_in     = ex_fc ? fc_total : sum_ext;
    q_rnd    = {q_in[ACC_W-1], q_in} + RND;
    q_sh     = q_rnd >>> QSHIFT;
    q_sat_c  = 1'b0;
    q_res    = q_sh[OUT_W-1:0];
    if (q_sh > Q_MAX) begin
      q_res   = Q_MAX[OUT_W-1:0];
      q_sat_c = 1'b1;
    end else if (q_sh < Q_MIN) begin
      q_res   = Q_MIN[OUT_W-1:0];
      q_sat_c = 1'b1;
    end
  end

  // Accumulate FC partials and track the expected partial index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      fc_part_idx <= '0;
    end else if (fc_clear) begin
      acc         <= '0;
      fc_part_idx <= '0;
    end else if (ex_fc) begin
      if (last_part) begin
        acc         <= '0;
        fc_part_idx <= '0;
      end else begin
        acc         <= fc_total;
        fc_part_idx <= fc_part_idx + IDX_W'(1);
      end
    end
  end

  // Quantiser register stage: CNN pulse, FC push request, saturation pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnn_out  <= 1'b0;
      q_fc_v   <= 1'b0;
      sat_flag <= 1'b0;
      q_data   <= '0;
    end else begin
      cnn_out  <= ex_cnn;
      q_fc_v   <= ex_fc & last_part;
      sat_flag <= (ex_cnn | (ex_fc & last_part)) & q_sat_c;
      if (ex_cnn | (ex_fc & last_part)) begin
        q_data <= q_res;
      end
    end
  end

  assign cnn_data_out = q_data;

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign full      = (count == (PTR_W + 1)'(OUT_DEPTH));
  assign pop       = out_valid & out_ready;
  // A pop frees the slot for a same-cycle push when full; no bypass when empty.
  assign do_push   = q_fc_v & (~full | pop);

  // FC output FIFO with sticky overflow; fc_clear clears ovf but keeps contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push) begin
        mem[wr_ptr] <= q_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_push && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (!do_push && pop) begin
        count <= count - (PTR_W + 1)'(1);
      end
      if (fc_clear) begin
        ovf <= 1'b0;
      end else if (q_fc_v && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnn_fc_core_ctl_gen.sv
// Scoreboard bench for cnn_fc_core_ctl_gen: driver pushes expected results
// from an arithmetic reference model, a negedge monitor pops and compares.
module tb_cnn_fc_core_ctl_gen;

  localparam int unsigned VEC_W     = 72;
  localparam int unsigned SUM_W     = 20;
  localparam int unsigned FC_PARTS  = 3;
  localparam int unsigned MAC_LAT   = 2;
  localparam int unsigned QSHIFT    = 4;
  localparam int unsigned OUT_W     = 8;
  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned IDX_W     = $clog2(FC_PARTS);

  typedef struct {
    logic [OUT_W-1:0] data;
    bit               sat;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cnn_valid = 1'b0;
  logic [VEC_W-1:0]    cnn_data = '0;
  logic [VEC_W-1:0]    filter_data = '0;
  logic                cnn_ack;
  logic                fc_valid = 1'b0;
  logic [VEC_W-1:0]    fc_data = '0;
  logic [VEC_W-1:0]    weight_data = '0;
  logic                fc_clear = 1'b0;
  logic [VEC_W-1:0]    mac_kernel;
  logic [VEC_W-1:0]    mac_weight;
  logic [SUM_W-1:0]    mac_sum;
  logic                cnn_out;
  logic [OUT_W-1:0]    cnn_data_out;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [OUT_W-1:0]    out_data;
  logic [IDX_W-1:0]    fc_part_idx;
  logic                sat_flag;
  logic                ovf;

  int   nchk = 0;
  int   nerr = 0;
  exp_t cnn_q[$];
  exp_t fc_q[$];
  int   fc_sat_exp = 0;
  int   fc_sat_seen = 0;
  longint m_acc = 0;
  int   m_cnt = 0;
  logic last_ack;

  cnn_fc_core_ctl_gen #(
    .VEC_W(VEC_W), .SUM_W(SUM_W), .FC_PARTS(FC_PARTS), .MAC_LAT(MAC_LAT),
    .QSHIFT(QSHIFT), .OUT_W(OUT_W), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cnn_valid(cnn_valid), .cnn_data(cnn_data), .filter_data(filter_data),
    .cnn_ack(cnn_ack),
    .fc_valid(fc_valid), .fc_data(fc_data), .weight_data(weight_data),
    .fc_clear(fc_clear),
    .mac_kernel(mac_kernel), .mac_weight(mac_weight), .mac_sum(mac_sum),
    .cnn_out(cnn_out), .cnn_data_out(cnn_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fc_part_idx(fc_part_idx), .sat_flag(sat_flag), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // External MAC: result = low SUM_W bits of kernel + weight, MAC_LAT cycles later
  logic [SUM_W-1:0] mpipe [MAC_LAT] = '{default: '0};
  always @(posedge clk) begin
    mpipe[0] <= mac_kernel[SUM_W-1:0] + mac_weight[SUM_W-1:0];
    for (int i = 1; i < MAC_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  always_comb mac_sum = mpipe[MAC_LAT-1];

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference quantiser: round-half-up, floor-divide by 2^QSHIFT, clamp
  function automatic exp_t quant(input longint x);
    exp_t   e;
    longint d  = longint'(1) << QSHIFT;
    longint r  = x + d / 2;
    longint q  = r / d;
    longint hi = (longint'(1) << (OUT_W - 1)) - 1;
    longint lo = -hi - 1;
    if ((r % d) != 0 && r < 0) q = q - 1;
    e.sat = 1'b0;
    if (q > hi) begin q = hi; e.sat = 1'b1; end
    else if (q < lo) begin q = lo; e.sat = 1'b1; end
    e.data = q[OUT_W-1:0];
    return e;
  endfunction

  task automatic make_ops(input int s, output logic [VEC_W-1:0] k, output logic [VEC_W-1:0] w);
    logic [95:0]      r1;
    logic [95:0]      r2;
    logic [SUM_W-1:0] a;
    r1 = {$urandom(), $urandom(), $urandom()};
    r2 = {$urandom(), $urandom(), $urandom()};
    a  = SUM_W'($urandom());
    k  = r1[VEC_W-1:0];
    w  = r2[VEC_W-1:0];
    k[SUM_W-1:0] = a;
    w[SUM_W-1:0] = SUM_W'(s) - a;
  endtask

  // One issue cycle: drive, update the reference model, sample ack mid-cycle
  task automatic beat(input bit fv, input int fs, input bit cv, input int cs, input bit clr);
    exp_t e;
    fc_valid  = fv;
    cnn_valid = cv;
    fc_clear  = clr;
    make_ops(fs, fc_data, weight_data);
    make_ops(cs, cnn_data, filter_data);
    if (clr) begin
      m_acc = 0;
      m_cnt = 0;
    end else if (fv) begin
      m_acc += fs;
      m_cnt++;
      if (m_cnt == FC_PARTS) begin
        e = quant(m_acc);
        fc_q.push_back(e);
        if (e.sat) fc_sat_exp++;
        m_acc = 0;
        m_cnt = 0;
      end
    end
    if (cv && !fv) cnn_q.push_back(quant(cs));
    @(negedge clk);
    last_ack = cnn_ack;
    @(posedge clk);
    #1;
    fc_valid  = 1'b0;
    cnn_valid = 1'b0;
    fc_clear  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    out_ready = 1'b1;
    while ((cnn_q.size() != 0 || fc_q.size() != 0) && c < maxc) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_timeout", c >= maxc, 0);
    idle(3);
  endtask

  // Monitor: mux/ack checks every cycle, scoreboard pops on output events
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("cnn_ack", cnn_ack, cnn_valid & ~fc_valid);
      nchk++;
      if (mac_kernel !== (fc_valid ? fc_data : cnn_data) ||
          mac_weight !== (fc_valid ? weight_data : filter_data)) begin
        nerr++;
        $display("FAIL mac_mux: kernel %h weight %h fc_valid %0b", mac_kernel, mac_weight, fc_valid);
      end
      if (cnn_out) begin
        if (cnn_q.size() == 0) begin
          chk("cnn_out_unexpected", 1, 0);
        end else begin
          e = cnn_q.pop_front();
          chk("cnn_data_out", cnn_data_out, e.data);
          chk("cnn_sat_flag", sat_flag, e.sat);
        end
      end else if (sat_flag) begin
        fc_sat_seen++;
      end
      if (out_valid && out_ready) begin
        if (fc_q.size() == 0) begin
          chk("fc_out_unexpected", 1, 0);
        end else begin
          e = fc_q.pop_front();
          chk("fc_out_data", out_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cpend;
    int csum;
    int fs;
    bit fv;
    bit prev_low;

    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cnn_out", cnn_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_fc_part_idx", fc_part_idx, 0);
    chk("rst_cnn_data_out", cnn_data_out, 0);
    @(posedge clk);
    #1;

    // Single CNN beat: pulse exactly MAC_LAT+1 cycles after the ack cycle
    beat(0, 0, 1, 'h150, 0);
    chk("cnn_ack_issue", last_ack, 1);
    @(negedge clk); chk("cnn_out_p1", cnn_out, 0);
    @(negedge clk); chk("cnn_out_p2", cnn_out, 0);
    @(negedge clk); chk("cnn_out_p3", cnn_out, 1);
    chk("cnn_data_0x15", cnn_data_out, 'h15);
    chk("cnn_sat0", sat_flag, 0);
    @(posedge clk); #1;
    idle(2);

    // FC triple 100,-20,40: index walks 1,2,0; out_valid four cycles after last issue
    beat(1, 100, 0, 0, 0);
    beat(1, -20, 0, 0, 0);
    beat(1, 40, 0, 0, 0);
    @(negedge clk); chk("fc_idx_1", fc_part_idx, 1);
    @(negedge clk); chk("fc_idx_2", fc_part_idx, 2);
    @(negedge clk); chk("fc_idx_0", fc_part_idx, 0);
    chk("fc_valid_p3", out_valid, 0);
    @(negedge clk); chk("fc_valid_p4", out_valid, 1);
    chk("fc_data_0x08", out_data, 'h08);
    @(posedge clk); #1;
    idle(3);

    // FC preempts CNN for three cycles; CNN accepted once FC drops
    for (int i = 0; i < 3; i++) begin
      beat(1, 16, 1, 'h40, 0);
      chk("cnn_ack_preempted", last_ack, 0);
    end
    beat(0, 0, 1, 'h40, 0);
    chk("cnn_ack_after_fc", last_ack, 1);
    drain(30);

    // Saturation both directions
    beat(0, 0, 1, 50000, 0);
    beat(0, 0, 1, -50000, 0);
    drain(30);

    // Randomised mix; out_ready never low two cycles running so the FIFO cannot fill
    cpend = 0;
    csum = 0;
    prev_low = 0;
    for (int i = 0; i < 300; i++) begin
      if (!cpend && $urandom_range(0, 1) == 1) begin
        cpend = 1;
        csum = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4000)) - 2000
                                           : int'($urandom_range(0, 1048575)) - 524288;
      end
      fv = ($urandom_range(0, 2) == 0);
      fs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1000)) - 500
                                       : int'($urandom_range(0, 1048575)) - 524288;
      out_ready = prev_low ? 1'b1 : ($urandom_range(0, 3) != 0);
      prev_low = !out_ready;
      beat(fv, fs, cpend, csum, 0);
      if (cpend && !fv) cpend = 0;
    end
    for (int i = m_cnt; i < FC_PARTS; i++) beat(1, 0, 0, 0, 0);
    drain(60);
    chk("ovf_after_random", ovf, 0);

    // Backpressure: five results into a four-deep FIFO with no pops
    out_ready = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      beat(1, 16 * r, 0, 0, 0);
      beat(1, 8, 0, 0, 0);
      beat(1, -8, 0, 0, 0);
    end
    // Full FIFO with no pop drops the fifth result.
    void'(fc_q.pop_back());
    idle(6);
    @(negedge clk);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_ovf_set", ovf, 1);
    chk("bp_queue_len", fc_q.size(), OUT_DEPTH);
    @(posedge clk); #1;
    drain(20);
    chk("bp_ovf_sticky", ovf, 1);
    chk("bp_fifo_empty", out_valid, 0);
    beat(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("bp_ovf_cleared", ovf, 0);
    @(posedge clk); #1;

    // fc_clear after two of three partials, second still in flight
    beat(1, 7, 0, 0, 0);
    beat(1, 9, 0, 0, 0);
    beat(0, 0, 0, 0, 1);
    idle(5);
    @(negedge clk);
    chk("clr_idx", fc_part_idx, 0);
    chk("clr_no_output", out_valid, 0);
    @(posedge clk); #1;
    beat(1, 10, 0, 0, 0);
    beat(1, 10, 0, 0, 0);
    beat(1, 10, 0, 0, 0);
    begin
      int c = 0;
      while (!out_valid && c < 10) begin
        @(negedge clk);
        c++;
      end
      chk("clr_wait_timeout", c >= 10, 0);
      chk("clr_triple_0x02", out_data, 'h02);
    end
    drain(20);

    chk("cnn_q_empty", cnn_q.size(), 0);
    chk("fc_q_empty", fc_q.size(), 0);
    chk("fc_sat_count", fc_sat_seen, fc_sat_exp);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
